// File: rtl/efi_sorter_pkg.sv
// efi_sorter_pkg: shared state type and the order-preserving sort key for the EFI sorter.
package efi_sorter_pkg;

    typedef enum logic {LOAD, SEND} state_t;

    localparam int KEY_MAX = 64;

    // Maps a value onto an unsigned key of w bits: sign-flip for integers and positive
    // floats, full inversion for negative floats, so -0 lands just below +0.
    function automatic logic [KEY_MAX-1:0] sort_key(input logic [KEY_MAX-1:0] d, input int w,
                                                    input logic fp);
        logic [KEY_MAX-1:0] msb;
        msb = KEY_MAX'(1) << (w - 1);
        return ((fp && (d & msb) != '0) ? ~d : d ^ msb) & ((msb << 1) - KEY_MAX'(1));
    endfunction

endpackage

// File: rtl/efi_sorter_cell.sv
// efi_sorter_cell: one buffer slot; keeps its entry, takes its lower neighbour's, or takes the
// new value, depending on its own compare and the compare of the slot below.
module efi_sorter_cell
    import efi_sorter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FLOAT_COMPARE = 1
) (
    input  logic                  clock,
    input  logic                  insert,
    input  logic                  occupied,
    input  logic                  below_le,
    input  logic [DATA_WIDTH-1:0] below_data,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [KEY_MAX-1:0]    new_key,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  le
);

    logic [KEY_MAX-1:0] key;

    always_comb begin
        key = sort_key(KEY_MAX'(data), DATA_WIDTH, FLOAT_COMPARE != 0);
        le  = occupied && key <= new_key;
    end

    // The slot where the lower neighbour is <= new but this one is not becomes the insert point.
    always_ff @(posedge clock)
        if (insert && !le) data <= below_le ? new_data : below_data;

endmodule

// File: rtl/efi_sorter.sv
// efi_sorter: fCore EFI responder that buffers an argument list by insertion and streams it
// back sorted ascending, one result per argument.
module efi_sorter
    import efi_sorter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_ARGS      = 16,
    parameter int FLOAT_COMPARE = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       efi_arguments_data,
    input  logic [$clog2(MAX_ARGS)-1:0] efi_arguments_dest,
    input  logic                        efi_arguments_valid,
    output logic                        efi_arguments_ready,
    input  logic                        efi_arguments_tlast,
    output logic [DATA_WIDTH-1:0]       efi_results_data,
    output logic [$clog2(MAX_ARGS)-1:0] efi_results_dest,
    output logic                        efi_results_valid,
    input  logic                        efi_results_ready,
    output logic                        efi_results_tlast,
    output logic                        overflow
);

    localparam int CW = $clog2(MAX_ARGS + 1);
    localparam int IW = $clog2(MAX_ARGS);

    state_t                state, state_next;
    logic [CW-1:0]         count, idx;
    logic                  arg_hs, res_hs, full, ins, last;
    logic [KEY_MAX-1:0]    new_key;
    logic [DATA_WIDTH-1:0] entries [MAX_ARGS];
    logic [MAX_ARGS:0]     le;
    logic                  unused_dest;

    assign unused_dest = ^efi_arguments_dest;
    assign le[0]       = 1'b1;
    assign new_key     = sort_key(KEY_MAX'(efi_arguments_data), DATA_WIDTH, FLOAT_COMPARE != 0);

    for (genvar i = 0; i < MAX_ARGS; i++) begin : g_cell
        efi_sorter_cell #(.DATA_WIDTH(DATA_WIDTH), .FLOAT_COMPARE(FLOAT_COMPARE)) u_cell (
            .clock      (clock),
            .insert     (ins),
            .occupied   (CW'(i) < count),
            .below_le   (le[i]),
            .below_data (i == 0 ? efi_arguments_data : entries[i == 0 ? 0 : i - 1]),
            .new_data   (efi_arguments_data),
            .new_key    (new_key),
            .data       (entries[i]),
            .le         (le[i+1])
        );
    end

    // Results come straight from registered state, so they hold steady under backpressure.
    always_comb begin
        efi_arguments_ready = state == LOAD;
        efi_results_valid   = state == SEND;
        arg_hs              = efi_arguments_ready && efi_arguments_valid;
        res_hs              = efi_results_valid && efi_results_ready;
        full                = count == CW'(MAX_ARGS);
        ins                 = arg_hs && !full;
        last                = idx == count - CW'(1);
        efi_results_data    = efi_results_valid ? entries[idx[IW-1:0]] : '0;
        efi_results_dest    = efi_results_valid ? idx[IW-1:0] : '0;
        efi_results_tlast   = efi_results_valid && last;
        state_next          = state;
        if (arg_hs && efi_arguments_tlast) state_next = SEND;
        if (res_hs && last) state_next = LOAD;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= LOAD;
            count    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (ins) count <= count + CW'(1);
            if (arg_hs && full) overflow <= 1'b1;
            if (res_hs) idx <= last ? '0 : idx + CW'(1);
            if (res_hs && last) begin
                count    <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_efi_sorter.sv
// tb_efi_sorter: scoreboard bench for efi_sorter in float and signed-integer builds.
module tb_efi_sorter;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dest;
        logic        last;
    } exp_t;

    logic        clock = 0;
    logic        reset = 1;
    logic [31:0] a_data = 0;
    logic [3:0]  a_dest = 0;
    logic        a_valid = 0, a_tlast = 0, res_ready = 0;
    int          sel = 0;
    logic [31:0] r_data0, r_data1, r_data;
    logic [3:0]  r_dest0, r_dest1, r_dest;
    logic        r_valid0, r_valid1, r_valid, r_tlast0, r_tlast1, r_tlast;
    logic        a_ready0, a_ready1, a_ready, ovf0, ovf1, ovf;
    logic        v0, v1;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    assign v0      = a_valid && sel == 0;
    assign v1      = a_valid && sel == 1;
    assign r_data  = sel == 1 ? r_data1 : r_data0;
    assign r_dest  = sel == 1 ? r_dest1 : r_dest0;
    assign r_valid = sel == 1 ? r_valid1 : r_valid0;
    assign r_tlast = sel == 1 ? r_tlast1 : r_tlast0;
    assign a_ready = sel == 1 ? a_ready1 : a_ready0;
    assign ovf     = sel == 1 ? ovf1 : ovf0;

    efi_sorter #(.DATA_WIDTH(32), .MAX_ARGS(16), .FLOAT_COMPARE(1)) dut_fp (
        .clock(clock), .reset(reset),
        .efi_arguments_data(a_data), .efi_arguments_dest(a_dest), .efi_arguments_valid(v0),
        .efi_arguments_ready(a_ready0), .efi_arguments_tlast(a_tlast),
        .efi_results_data(r_data0), .efi_results_dest(r_dest0), .efi_results_valid(r_valid0),
        .efi_results_ready(res_ready), .efi_results_tlast(r_tlast0), .overflow(ovf0)
    );

    efi_sorter #(.DATA_WIDTH(32), .MAX_ARGS(16), .FLOAT_COMPARE(0)) dut_int (
        .clock(clock), .reset(reset),
        .efi_arguments_data(a_data), .efi_arguments_dest(a_dest), .efi_arguments_valid(v1),
        .efi_arguments_ready(a_ready1), .efi_arguments_tlast(a_tlast),
        .efi_results_data(r_data1), .efi_results_dest(r_dest1), .efi_results_valid(r_valid1),
        .efi_results_ready(res_ready), .efi_results_tlast(r_tlast1), .overflow(ovf1)
    );

    // Strict less-than written from sign/magnitude reasoning rather than a key transform.
    function automatic logic lt(input logic [31:0] a, input logic [31:0] b, input int fp);
        if (fp == 0) return $signed(a) < $signed(b);
        if (a[31] != b[31]) return a[31];
        return a[31] ? a > b : a < b;
    endfunction

    task automatic push_exp(input logic [31:0] v[$]);
        foreach (v[i]) exp_q.push_back('{data: v[i], dest: 4'(i), last: i == v.size() - 1});
    endtask

    task automatic model(input logic [31:0] a[$], input int fp);
        logic [31:0] s[$];
        int j;
        s = {};
        foreach (a[i]) begin
            if (i >= 16) break;
            j = 0;
            while (j < s.size() && !lt(a[i], s[j], fp)) j++;
            s.insert(j, a[i]);
        end
        push_exp(s);
    endtask

    task automatic drive(input logic [31:0] a[$], input logic with_last);
        foreach (a[i]) begin
            @(negedge clock);
            a_data  = a[i];
            a_dest  = 4'($urandom);
            a_valid = 1;
            a_tlast = with_last && i == a.size() - 1;
            vectors++;
            if (a_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL arg_ready beat %0d: got %b want 1", i, a_ready);
            end
            @(posedge clock);
        end
        @(negedge clock);
        a_valid = 0;
        a_tlast = 0;
    endtask

    // Entered on the negedge right after the tlast beat; pat 0 = always ready, 1 = 1010.., 2 = random.
    task automatic collect(input int pat);
        int cyc;
        logic done, stalled;
        logic [31:0] held_data;
        logic [3:0] held_dest;
        exp_t e;
        done = 0;
        stalled = 0;
        cyc = 0;
        vectors++;
        if (r_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: valid %b one cycle after tlast, want 1", r_valid);
        end
        while (!done && cyc < 200) begin
            res_ready = pat == 0 ? 1'b1 : pat == 1 ? cyc % 2 == 0 : 1'($urandom_range(0, 1));
            if (stalled) begin
                vectors++;
                if (r_data !== held_data || r_dest !== held_dest) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h/%0d want %h/%0d", r_data, r_dest, held_data, held_dest);
                end
            end
            stalled = 0;
            if (r_valid === 1'b1) begin
                vectors++;
                if (a_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arg_ready_in_send: got %b want 0", a_ready);
                end
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_result: got %h with nothing expected", r_data);
                        done = 1;
                    end else begin
                        e = exp_q.pop_front();
                        vectors++;
                        if (r_data !== e.data || r_dest !== e.dest || r_tlast !== e.last) begin
                            miscompares++;
                            $display("FAIL result: got %h dest %0d tlast %b want %h dest %0d tlast %b",
                                     r_data, r_dest, r_tlast, e.data, e.dest, e.last);
                        end
                        done = e.last;
                    end
                end else begin
                    stalled = 1;
                    held_data = r_data;
                    held_dest = r_dest;
                end
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        res_ready = 0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout: %0d results still expected", exp_q.size());
        end
        vectors++;
        if (r_valid !== 1'b0 || a_ready !== 1'b1 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_load: valid %b arg_ready %b overflow %b want 0 1 0", r_valid, a_ready, ovf);
        end
        exp_q.delete();
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 0;
        a_valid = 0;
        res_ready = 0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            vectors++;
            if (r_valid !== 0 || r_tlast !== 0 || r_data !== 0 || r_dest !== 0 || ovf !== 0 || a_ready !== 1) begin
                miscompares++;
                $display("FAIL reset dut%0d: valid %b tlast %b data %h dest %0d ovf %b ready %b",
                         s, r_valid, r_tlast, r_data, r_dest, ovf, a_ready);
            end
        end
        reset = 1;
        sel = 0;
    endtask

    task automatic test_float;
        logic [31:0] q[$];
        sel = 0;
        q = {32'h40400000, 32'hBF800000, 32'h3F000000, 32'hC0000000};
        drive(q, 1);
        q = {32'hC0000000, 32'hBF800000, 32'h3F000000, 32'h40400000};
        push_exp(q);
        collect(0);
    endtask

    task automatic test_signed;
        logic [31:0] q[$];
        sel = 1;
        q = {32'd5, 32'hFFFFFFFD, 32'd5, 32'd0};
        drive(q, 1);
        q = {32'hFFFFFFFD, 32'd0, 32'd5, 32'd5};
        push_exp(q);
        collect(0);
        q = {32'd7, 32'h80000000, 32'd7, 32'h7FFFFFFF, 32'd7, 32'hFFFFFFFF};
        drive(q, 1);
        q = {32'h80000000, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd7, 32'h7FFFFFFF};
        push_exp(q);
        collect(2);
        sel = 0;
    endtask

    task automatic test_overflow;
        logic [31:0] q[$];
        logic [31:0] e[$];
        sel = 1;
        q = {};
        e = {};
        for (int i = 1; i <= 18; i++) q.push_back(32'(i));
        for (int i = 1; i <= 16; i++) e.push_back(32'(i));
        drive(q, 1);
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b want 1", ovf);
        end
        push_exp(e);
        collect(0);
        sel = 0;
    endtask

    task automatic test_backpressure;
        logic [31:0] q[$];
        sel = 0;
        q = {32'h40400000, 32'hBF800000, 32'h3F000000, 32'hC0000000};
        drive(q, 1);
        q = {32'hC0000000, 32'hBF800000, 32'h3F000000, 32'h40400000};
        push_exp(q);
        collect(1);
    endtask

    task automatic test_single;
        logic [31:0] q[$];
        sel = 0;
        q = {32'h80000000};
        drive(q, 1);
        push_exp(q);
        collect(0);
        q = {32'h00000000, 32'h80000000};
        drive(q, 1);
        q = {32'h80000000, 32'h00000000};
        push_exp(q);
        collect(0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] q[$];
        sel = 1;
        q = {32'd9, 32'd8};
        drive(q, 0);
        do_reset();
        reset = 1;
        q = {32'd2, 32'd1, 32'd3};
        drive(q, 1);
        q = {32'd1, 32'd2, 32'd3};
        push_exp(q);
        collect(0);
        sel = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] q[$];
        logic [31:0] pool[4];
        for (int k = 0; k < 4; k++) pool[k] = $urandom;
        for (int c = 0; c < 6; c++) begin
            sel = c % 2;
            q = {};
            for (int i = 0; i < $urandom_range(1, 16); i++)
                q.push_back($urandom_range(0, 2) == 0 ? pool[$urandom_range(0, 3)] : $urandom);
            drive(q, 1);
            model(q, sel == 0 ? 1 : 0);
            collect(2);
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_float();
        test_signed();
        test_overflow();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
